writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 37 +++
 rtl/writeback_unit_fifo.sv | 67 ++++++
 rtl/writeback_unit.sv | 112 +++++++++++
 tb/tb_writeback_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the ALU result writeback path: opcode constants, field widths,
// FSM state encoding and the queued result entry layout.
package writeback_unit_pkg;

    localparam int unsigned OPC_W  = 6;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    localparam logic [OPC_W-1:0] OP_MUL = 6'b000111;
    localparam logic [OPC_W-1:0] OP_MAX = 6'b010000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [ADDR_W-1:0] rdst1;
        logic [ADDR_W-1:0] rdst2;
        logic [WORD_W-1:0] result;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

    function automatic logic is_mul(input logic [OPC_W-1:0] op);
        return op == OP_MUL;
    endfunction

    // Opcodes beyond OP_MAX carry no register write.
    function automatic logic is_nop(input logic [OPC_W-1:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/writeback_unit_fifo.sv
// Result FIFO (wb_fifo): circular buffer of 48-bit entries that also exposes every slot
// and a per-slot valid mask so the top can compute register hazards.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output wb_entry_t [DEPTH-1:0]  entries,
    output logic      [DEPTH-1:0]  entry_valid
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [AW:0]           count_q;
    wb_entry_t [DEPTH-1:0] mem_q;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rptr_q];
    assign entries = mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] offset;
            offset         = AW'(i) - rptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: queues ALU results and retires them into the register file as one or two
// 16-bit writes per entry, tracking registers with outstanding writes.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned NREGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [ADDR_W-1:0] in_rdst1,
    input  logic [ADDR_W-1:0] in_rdst2,
    input  logic [WORD_W-1:0] in_result,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [HALF_W-1:0] rf_wdata,
    output logic              retire,
    output logic [NREGS-1:0]  pending
);

    wb_entry_t             in_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] entry_valid;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  pop;

    wb_state_e state_q;
    wb_entry_t cur_q;

    assign in_entry = '{opcode: in_opcode, rdst1: in_rdst1, rdst2: in_rdst2, result: in_result};
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;

    // The head is consumed whenever the current entry has no further write to issue.
    assign pop = !empty && ((state_q == IDLE) || (state_q == WR_HI) ||
                            ((state_q == WR_LO) && !is_mul(cur_q.opcode)));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (accept),
        .push_data   (in_entry),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retire   <= 1'b0;
        end else if ((state_q == WR_LO) && is_mul(cur_q.opcode)) begin
            state_q  <= WR_HI;
            rf_we    <= 1'b1;
            rf_waddr <= cur_q.rdst2;
            rf_wdata <= cur_q.result[WORD_W-1:HALF_W];
            retire   <= 1'b1;
        end else if (pop) begin
            state_q  <= WR_LO;
            cur_q    <= head;
            rf_we    <= !is_nop(head.opcode);
            rf_waddr <= head.rdst1;
            rf_wdata <= head.result[HALF_W-1:0];
            retire   <= !is_mul(head.opcode);
        end else begin
            state_q  <= IDLE;
            rf_we    <= 1'b0;
            retire   <= 1'b0;
        end
    end

    function automatic logic [NREGS-1:0] reg_bit(input logic [ADDR_W-1:0] addr);
        logic [NREGS-1:0] v;
        v = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (addr == ADDR_W'(r)) v[r] = 1'b1;
        end
        return v;
    endfunction

    // In-flight contribution includes the write currently on the rf_* outputs.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !is_nop(entries[i].opcode)) begin
                pending = pending | reg_bit(entries[i].rdst1);
                if (is_mul(entries[i].opcode)) pending = pending | reg_bit(entries[i].rdst2);
            end
        end
        if ((state_q == WR_LO) && !is_nop(cur_q.opcode)) begin
            pending = pending | reg_bit(cur_q.rdst1);
            if (is_mul(cur_q.opcode)) pending = pending | reg_bit(cur_q.rdst2);
        end
        if (state_q == WR_HI) pending = pending | reg_bit(cur_q.rdst2);
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed entries queue their hand-computed writes,
// a negedge monitor pops and compares every write/retire cycle the DUT presents.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rdst1;
    logic [4:0]  in_rdst2;
    logic [31:0] in_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        retire;
    logic [31:0] pending;

    writeback_unit #(
        .DEPTH (2),
        .NREGS (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rdst1  (in_rdst1),
        .in_rdst2  (in_rdst2),
        .in_result (in_result),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .retire    (retire),
        .pending   (pending)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] data;
        logic        ret;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   wr_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stalls = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (rf_we || retire)) begin
            wr_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write we %0b addr %0h data %0h retire %0b want none",
                         rf_we, rf_waddr, rf_wdata, retire);
            end else begin
                mon_e = expq.pop_front();
                chk("wb_we", {31'd0, rf_we}, {31'd0, mon_e.we});
                if (mon_e.we) begin
                    chk("wb_addr", {27'd0, rf_waddr}, {27'd0, mon_e.addr});
                    chk("wb_data", {16'd0, rf_wdata}, {16'd0, mon_e.data});
                end
                chk("wb_retire", {31'd0, retire}, {31'd0, mon_e.ret});
            end
        end
    end

    task automatic expect_wr(input logic we, input logic [4:0] a, input logic [15:0] d,
                             input logic r);
        exp_t e;
        e.we   = we;
        e.addr = a;
        e.data = d;
        e.ret  = r;
        expq.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] res);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rdst1  = r1;
        in_rdst2  = r2;
        in_result = res;
        stalls    = 0;
        while (!in_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready %0b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", expq.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n0;
        int sb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rdst1  = '0;
        in_rdst2  = '0;
        in_result = '0;
        repeat (3) @(negedge clk);

        chk("rst_we", {31'd0, rf_we}, 0);
        chk("rst_waddr", {27'd0, rf_waddr}, 0);
        chk("rst_wdata", {16'd0, rf_wdata}, 0);
        chk("rst_retire", {31'd0, retire}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_pending", pending, 0);

        // ADD accepted on the very first edge after release.
        rst_n = 1'b1;
        expect_wr(1'b1, 5'd3, 16'h1234, 1'b1);
        push(6'b000100, 5'd3, 5'd0, 32'h0000_1234);
        chk("add_pending_queued", {31'd0, pending[3]}, 1);
        chk("add_latency_not_yet", {31'd0, rf_we}, 0);
        @(negedge clk);
        chk("add_latency_we", {31'd0, rf_we}, 1);
        chk("add_pending_inflight", {31'd0, pending[3]}, 1);
        @(negedge clk);
        chk("add_pending_clear", pending, 0);

        // MUL: low then high half, retire only on the second.
        expect_wr(1'b1, 5'd4, 16'h0123, 1'b0);
        expect_wr(1'b1, 5'd5, 16'hABCD, 1'b1);
        push(6'b000111, 5'd4, 5'd5, 32'hABCD_0123);
        drain();

        // MUL then three ADDs back-to-back; the third ADD stalls on a full FIFO.
        expect_wr(1'b1, 5'd10, 16'h2222, 1'b0);
        expect_wr(1'b1, 5'd11, 16'h1111, 1'b1);
        expect_wr(1'b1, 5'd1, 16'h0AAA, 1'b1);
        expect_wr(1'b1, 5'd2, 16'h0BBB, 1'b1);
        expect_wr(1'b1, 5'd6, 16'h0CCC, 1'b1);
        n0 = wr_cyc.size();
        push(6'b000111, 5'd10, 5'd11, 32'h1111_2222);
        push(6'b000001, 5'd1, 5'd0, 32'h0000_0AAA);
        push(6'b000010, 5'd2, 5'd0, 32'h0000_0BBB);
        sb = stalls;
        push(6'b000011, 5'd6, 5'd0, 32'h0000_0CCC);
        chk("b2b_no_stall_second_add", sb, 0);
        chk("b2b_full_stall", stalls, 1);
        drain();
        chk("b2b_write_count", wr_cyc.size() - n0, 5);
        if (wr_cyc.size() >= n0 + 5) chk("b2b_no_bubble", wr_cyc[n0+4] - wr_cyc[n0], 4);

        // MUL to the same register twice: high half last.
        expect_wr(1'b1, 5'd7, 16'h0002, 1'b0);
        expect_wr(1'b1, 5'd7, 16'h0001, 1'b1);
        push(6'b000111, 5'd7, 5'd7, 32'h0001_0002);
        drain();

        // Out-of-range opcode between two ADDs: a silent retire slot.
        expect_wr(1'b1, 5'd12, 16'h0012, 1'b1);
        expect_wr(1'b0, 5'd0, 16'h0000, 1'b1);
        expect_wr(1'b1, 5'd14, 16'h0014, 1'b1);
        push(6'b000101, 5'd12, 5'd0, 32'h0000_0012);
        push(6'b111111, 5'd13, 5'd13, 32'hFFFF_FFFF);
        push(6'b000110, 5'd14, 5'd0, 32'h0000_0014);
        drain();

        // Reset in the WR_LO slot of a MUL abandons the high write.
        expect_wr(1'b1, 5'd8, 16'h0008, 1'b0);
        push(6'b000111, 5'd8, 5'd9, 32'h0009_0008);
        @(negedge clk);
        chk("mul_lo_pending_hi", {31'd0, pending[9]}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, rf_we}, 0);
        chk("midrst_retire", {31'd0, retire}, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = wr_cyc.size();
        repeat (4) @(negedge clk);
        chk("postrst_no_writes", wr_cyc.size() - n0, 0);
        expect_wr(1'b1, 5'd15, 16'h00FF, 1'b1);
        push(6'b000100, 5'd15, 5'd0, 32'h0000_00FF);
        drain();
        chk("final_pending", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
